// File: rtl/flatten_collector.sv
// Packs CHUNK_W-bit pooled rows into the flat NUM_INPUTS-bit vector for the final layer.
// Define FLATTEN_POPCOUNT_EN to add a saturating ones counter over the accepted beats.
module flatten_collector #(
  parameter int NUM_INPUTS = 196,
  parameter int CHUNK_W    = 14
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [2:0]            state,
  input  logic                  in_valid,
  input  logic [CHUNK_W-1:0]    in_data,
  output logic                  in_ready,
  output logic [NUM_INPUTS-1:0] data_out,
  output logic                  flatten_done,
  output logic [7:0]            ones_count
);

  localparam int NUM_BEATS = NUM_INPUTS / CHUNK_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_LAYER_2 = 3'b011;

  if (NUM_INPUTS % CHUNK_W != 0) begin : g_chunk_check
    $error("flatten_collector: NUM_INPUTS must be a multiple of CHUNK_W");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  start;
  logic                  accept;

  // in_ready follows state combinationally so a pause takes effect in the same cycle.
  assign in_ready = (fsm_q == COLLECT) && (state == S_LAYER_2);
  assign accept   = in_ready && in_valid;
  assign start    = (fsm_q == IDLE) && (state == S_LAYER_2);

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    done_d = done_q;
    if (state == S_IDLE) begin
      fsm_d  = IDLE;
      done_d = 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            fsm_d  = COLLECT;
            cnt_d  = '0;
            data_d = '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
              if (cnt_q == CNT_W'(b)) data_d[b*CHUNK_W +: CHUNK_W] = in_data;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_BEATS - 1)) begin
              fsm_d  = FULL;
              done_d = 1'b1;
            end
          end
        end
        FULL:    ;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign data_out     = data_q;
  assign flatten_done = done_q;

`ifdef FLATTEN_POPCOUNT_EN
  function automatic logic [7:0] sat_popcount_add(input logic [7:0]         acc,
                                                   input logic [CHUNK_W-1:0] beat);
    logic [7:0] res;
    res = acc;
    for (int i = 0; i < CHUNK_W; i++) begin
      if (beat[i] && (res != 8'hFF)) res = res + 8'd1;
    end
    return res;
  endfunction

  logic [7:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (start)       ones_d = 8'd0;
    else if (accept) ones_d = sat_popcount_add(ones_q, in_data);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ones_q <= 8'd0;
    else          ones_q <= ones_d;
  end

  assign ones_count = ones_q;
`else
  assign ones_count = 8'd0;
`endif

endmodule

// File: tb/tb_flatten_collector.sv
// Scoreboard bench for flatten_collector: directed plan scenarios plus randomized runs
// checked against a beat-queue reference model.
module tb_flatten_collector;
  localparam int NI = 196;
  localparam int CW = 14;
  localparam int NB = NI / CW;
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_L2    = 3'b011;
  localparam logic [2:0] S_L3    = 3'b100;
  localparam logic [2:0] S_OTHER = 3'b010;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [2:0]    state_i;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic          in_ready;
  logic [NI-1:0] data_out;
  logic          flatten_done;
  logic [7:0]    ones_count;

  always #5 clock = ~clock;

  flatten_collector #(.NUM_INPUTS(NI), .CHUNK_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .state(state_i), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .data_out(data_out),
    .flatten_done(flatten_done), .ones_count(ones_count)
  );

  int checks = 0;
  int failures = 0;
  int tick_no = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 full; the vector is derived from the beat list.
  int            m_phase = 0;
  logic [CW-1:0] m_beats[$];
  logic          m_done = 1'b0;

  typedef struct {
    logic [NI-1:0] vec;
    logic [7:0]    ones;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [NI-1:0] m_vec();
    logic [NI-1:0] v;
    v = '0;
    for (int i = 0; i < m_beats.size(); i++) v[i*CW +: CW] = m_beats[i];
    return v;
  endfunction

  function automatic logic [7:0] m_ones();
`ifdef FLATTEN_POPCOUNT_EN
    int pc;
    pc = $countones(m_vec());
    return (pc > 255) ? 8'hFF : 8'(pc);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [NI-1:0] act, input logic [NI-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  task automatic model_step(input logic [2:0] st, input logic v, input logic [CW-1:0] d);
    tick_no++;
    if (st == S_IDLE) begin
      m_phase = 0;
      m_done  = 1'b0;
    end else if (m_phase == 0) begin
      if (st == S_L2) begin
        m_phase = 1;
        m_beats.delete();
      end
    end else if (m_phase == 1 && st == S_L2 && v) begin
      m_beats.push_back(d);
      if (m_beats.size() == NB) begin
        m_phase = 2;
        m_done  = 1'b1;
        sb.push_back('{m_vec(), m_ones(), tick_no});
      end
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic tick(input logic [2:0] st, input logic v, input logic [CW-1:0] d);
    logic exp_ready;
    state_i  = st;
    in_valid = v;
    in_data  = d;
    exp_ready = (m_phase == 1) && (st == S_L2);
    @(negedge clock);
    chk("in_ready", NI'(in_ready), NI'(exp_ready));
    chk("flatten_done", NI'(flatten_done), NI'(m_done));
    chk("data_out", data_out, m_vec());
    chk("ones_count", NI'(ones_count), NI'(m_ones()));
    @(posedge clock);
    model_step(st, v, d);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, data_out, '0);
    chk({tag, "_done"}, NI'(flatten_done), '0);
    chk({tag, "_ready"}, NI'(in_ready), '0);
    chk({tag, "_ones"}, NI'(ones_count), '0);
  endtask

  // Monitor: pops an expectation on each rising edge of flatten_done.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && flatten_done && !prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_done actual=1 required=0 (tick %0d)", tick_no);
        end else begin
          e = sb.pop_front();
          chk("sb_data", data_out, e.vec);
          chk("sb_ones", NI'(ones_count), NI'(e.ones));
          chk("sb_latency", NI'(tick_no), NI'(e.cyc));
        end
      end
      prev = flatten_done;
    end
  end

  initial begin : stim
    logic [2:0] st;
    int x;
    reset_n  = 1'b0;
    state_i  = S_IDLE;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Nominal: one-hot beats, back to back
    tick(S_L2, 1'b0, '0);
    for (int k = 0; k < NB; k++) tick(S_L2, 1'b1, CW'(1) << k);
    tick(S_L2, 1'b0, '0);
    tick(S_L2, 1'b0, '0);

    // Throttled valid, all-ones beats
    tick(S_IDLE, 1'b0, '0);
    tick(S_L2, 1'b0, '0);
    for (int i = 0; i < 3 * NB; i++) tick(S_L2, (i % 3) == 0, 14'h3FFF);

    // Overrun after FULL
    for (int i = 0; i < 5; i++) tick(S_L2, 1'b1, 14'h0000);

    // Hold then resume
    tick(S_IDLE, 1'b0, '0);
    tick(S_L2, 1'b0, '0);
    for (int i = 0; i < 6; i++) tick(S_L2, 1'b1, CW'($urandom));
    for (int i = 0; i < 4; i++) tick(S_OTHER, 1'b1, CW'($urandom));
    for (int i = 0; i < 8; i++) tick(S_L2, 1'b1, CW'($urandom));
    tick(S_L2, 1'b0, '0);

    // Reset mid-collection, then a fresh run
    tick(S_IDLE, 1'b0, '0);
    tick(S_L2, 1'b0, '0);
    for (int i = 0; i < 9; i++) tick(S_L2, 1'b1, CW'($urandom));
    reset_n = 1'b0;
    #1;
    m_phase = 0;
    m_done  = 1'b0;
    m_beats.delete();
    check_zero("async_reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick(S_IDLE, 1'b0, '0);
    tick(S_L2, 1'b0, '0);
    for (int i = 0; i < NB; i++) tick(S_L2, 1'b1, CW'($urandom));

    // Hold through layer 3, then back to idle
    for (int i = 0; i < 50; i++) tick(S_L3, CW'($urandom_range(0, 1)) != 0, CW'($urandom));
    tick(S_IDLE, 1'b0, '0);
    tick(S_IDLE, 1'b0, '0);

    // Randomized runs with pauses and throttled valid
    for (int r = 0; r < 4; r++) begin
      tick(S_IDLE, 1'b0, '0);
      tick(S_L2, 1'b0, '0);
      for (int i = 0; i < 300 && m_phase != 2; i++) begin
        x  = $urandom_range(0, 9);
        st = (x == 7) ? S_OTHER : (x == 8) ? S_L3 : S_L2;
        tick(st, ($urandom % 2) == 1, CW'($urandom));
      end
      for (int i = 0; i < 3; i++) tick(S_L3, 1'b1, CW'($urandom));
    end

    tick(S_IDLE, 1'b0, '0);
    chk("sb_drained", NI'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flatten_collector.md
Name: flatten_collector

Overview:
- Assembles the NUM_INPUTS-bit binarised activation vector consumed by the final classification layer.
- Receives CHUNK_W-bit beats from the pooling layer over a valid/ready handshake while the top-level state is s_LAYER_2.
- Packs the beats into a flat register and holds it stable through s_LAYER_3.
- Raises flatten_done once the vector is complete, so the top-level FSM can advance.

Parameters:
- NUM_INPUTS, 196, total bits in the flattened vector.
- CHUNK_W, 14, bits per input beat (one pooled row). NUM_INPUTS must be an exact multiple of CHUNK_W; an elaboration-time check fails otherwise.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- state  input  3  top-level state: s_IDLE=3'b000, s_LAYER_2=3'b011, s_LAYER_3=3'b100.
- in_valid  input  1  the beat on in_data is valid.
- in_data  input  CHUNK_W  activation beat; bit 0 is the lowest column index.
- in_ready  output  1  collector accepts a beat this cycle.
- data_out  output  NUM_INPUTS  packed vector, feeds the final layer's data_in.
- flatten_done  output  1  vector complete and stable.
- ones_count  output  8  population count of data_out (optional feature only).

Behaviour:
- Reset, asynchronous, active-low:
  - data_out=0, flatten_done=0, in_ready=0, ones_count=0.
  - Beat counter=0, FSM=IDLE.
- Internal FSM states: IDLE, COLLECT, FULL.
- IDLE -> COLLECT: on the first cycle with state==s_LAYER_2. The beat counter and data_out are cleared on that edge.
- COLLECT:
  - in_ready=1 only while state==s_LAYER_2.
  - A beat is accepted on a clock edge where in_valid && in_ready.
  - Beat k (0-based) is written to data_out[k*CHUNK_W +: CHUNK_W]. Other bits are untouched.
  - The beat counter increments on each accepted beat and is wide enough for NUM_INPUTS/CHUNK_W.
  - The last beat (k = NUM_INPUTS/CHUNK_W-1) is written and the FSM moves to FULL on the same edge. flatten_done=1 from the following cycle, i.e. latency of 1 clock after the last handshake.
  - If state leaves s_LAYER_2 mid-collection (any value other than s_IDLE): in_ready drops combinationally, the beat counter and data_out hold, and collection resumes when state returns to s_LAYER_2.
- FULL:
  - in_ready=0. in_valid is ignored, so extra beats are never written.
  - data_out and flatten_done hold through s_LAYER_2 and s_LAYER_3.
- state==s_IDLE from any FSM state: synchronous return to IDLE on the next edge. flatten_done=0; data_out is cleared on the IDLE -> COLLECT transition, not on entry to IDLE.
- in_valid held low: no change. The handshake has no timeout.
- Back-to-back beats: one beat per cycle is sustained. in_ready does not depend on in_valid.
- Reset mid-collection: immediate return to reset values; partial data is discarded.

Optional Feature:
- FLATTEN_POPCOUNT_EN defined:
  - ones_count accumulates popcount(in_data) on every accepted beat, saturating at 255.
  - It is cleared on the IDLE -> COLLECT transition.
  - It is valid, and equal to popcount(data_out), whenever flatten_done=1.
- Not defined: ones_count is tied to 8'd0, and no popcount logic is synthesised.

Test Plan:
- Nominal collection:
  - Stimulus: reset; state=s_LAYER_2; 14 back-to-back beats, beat k = 14'h0001<<k.
  - Response: in_ready=1 throughout; flatten_done=1 exactly one cycle after the 14th handshake; data_out bit k*15 set for k=0..13 and all other bits 0; ones_count=14 with FLATTEN_POPCOUNT_EN.
- Throttled valid:
  - Stimulus: in_valid toggles 1,0,0,1,... with beats 14'h3FFF.
  - Response: only valid cycles are counted; data_out is all ones after 14 accepted beats; ones_count=196.
- Overrun:
  - Stimulus: keep in_valid=1 with data 14'h0000 for 5 cycles after FULL.
  - Response: in_ready=0, and data_out stays all ones.
- Hold then resume:
  - Stimulus: after 6 beats, set state=3'b010 for 4 cycles with in_valid=1, then return to s_LAYER_2.
  - Response: in_ready=0 during the hold and the counter stays at 6; collection completes after 8 more beats.
- Reset and re-run:
  - Stimulus: assert reset_n=0 after 9 beats; release; then drive state=s_IDLE then s_LAYER_2.
  - Response: all outputs return to 0 immediately; a fresh 14-beat run completes correctly.
- State sequence:
  - Stimulus: after FULL, drive state=s_LAYER_3 for 50 cycles, then s_IDLE.
  - Response: data_out and flatten_done hold for the 50 cycles; flatten_done=0 one cycle after s_IDLE.
